// File: rtl/load_store_buffer_pkg.sv
// Shared types for the load/store buffer: op codes, access lengths, queue entry and FSM state.
package load_store_buffer_pkg;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;

    localparam logic [OP_W-1:0] OP_LB  = 6'd11;
    localparam logic [OP_W-1:0] OP_LH  = 6'd12;
    localparam logic [OP_W-1:0] OP_LW  = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU = 6'd15;
    localparam logic [OP_W-1:0] OP_SB  = 6'd16;
    localparam logic [OP_W-1:0] OP_SH  = 6'd17;
    localparam logic [OP_W-1:0] OP_SW  = 6'd18;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
        logic [31:0]      data;
    } lsb_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} lsb_state_e;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic [1:0] op_len(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return LEN_BYTE;
            OP_LH, OP_LHU, OP_SH: return LEN_HALF;
            default:              return LEN_WORD;
        endcase
    endfunction
endpackage

// File: rtl/load_store_buffer_if.sv
// Memory-controller bus between the load/store buffer (master) and the memory controller (slave).
interface load_store_buffer_if;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
                    input  mem_done, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
                    output mem_done, mem_rdata);
endinterface

// File: rtl/load_store_buffer_load_extend.sv
// Turns raw right-aligned read data into the architectural load value for the given op.
module lsb_load_extend
    import load_store_buffer_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rdata,
    output logic [31:0]     value
);
    always_comb begin
        case (op)
            OP_LB:   value = {{24{rdata[7]}}, rdata[7:0]};
            OP_LH:   value = {{16{rdata[15]}}, rdata[15:0]};
            OP_LBU:  value = {24'd0, rdata[7:0]};
            OP_LHU:  value = {16'd0, rdata[15:0]};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: one memory access at a time, stores wait for ROB commit,
// results and store-ready notices share the CDB port.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int          LSBSIZE = 8,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ls_mission,
    input  logic [TAG_W-1:0]  ls_ins_rnm,
    input  logic [OP_W-1:0]   ls_op_type,
    input  logic [31:0]       ls_addr_offset,
    input  logic [31:0]       ls_ins_rs1,
    input  logic [31:0]       store_ins_rs2,
    output logic              lsb_full,
    input  logic              rob_store_commit,
    input  logic [TAG_W-1:0]  rob_commit_rename,
    input  logic [TAG_W-1:0]  rob_head_rename,
    input  logic              lsb_flush,
    load_store_buffer_if.master mem,
    output logic              lsb_result_flag,
    output logic [TAG_W-1:0]  lsb_result_rename,
    output logic [31:0]       lsb_result_value
);
    localparam int PW = $clog2(LSBSIZE);
    localparam int CW = PW + 1;

    lsb_entry_t       q [LSBSIZE];
    logic [LSBSIZE-1:0] cmt, ann;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    lsb_state_e       state;

    lsb_entry_t       hd;
    logic [31:0]      ld_value;
    logic             done, busy_load, load_bcast, enq, head_ready, issue;
    logic [LSBSIZE-1:0] commit_hit;
    logic             note_vld, run;
    logic [PW-1:0]    note_idx;
    logic [CW-1:0]    keep;

    assign hd       = q[head];
    assign lsb_full = count >= CW'(LSBSIZE - 1);

    lsb_load_extend u_ext (.op(hd.op), .rdata(mem.mem_rdata), .value(ld_value));

    assign done       = (state != S_IDLE) && mem.mem_done;
    assign busy_load  = (state != S_IDLE) && !is_store(hd.op);
    assign load_bcast = done && (state == S_BUSY) && !is_store(hd.op) && !lsb_flush;
    assign enq        = ls_mission && !lsb_flush && (count != CW'(LSBSIZE));
    assign issue      = (state == S_IDLE) && head_ready && !lsb_flush;

    always_comb begin
        head_ready = 1'b0;
        if (count != '0) begin
            if (is_store(hd.op)) head_ready = cmt[head];
            else                 head_ready = (hd.addr < IO_BASE) || (hd.tag == rob_head_rename);
        end
    end

    always_comb begin
        commit_hit = '0;
        for (int j = 0; j < LSBSIZE; j++)
            commit_hit[j] = rob_store_commit && is_store(q[j].op) && (q[j].tag == rob_commit_rename)
                            && ({1'b0, PW'(j) - head} < count);
    end

    // One walk from head finds the oldest unannounced store and the committed prefix that
    // survives a flush; a load still on the bus stays counted until its drain completes.
    always_comb begin
        keep     = '0;
        run      = 1'b1;
        note_vld = 1'b0;
        note_idx = head;
        for (int i = 0; i < LSBSIZE; i++) begin
            if (CW'(i) < count) begin
                if (!note_vld && is_store(q[head + PW'(i)].op) && !ann[head + PW'(i)]) begin
                    note_vld = 1'b1;
                    note_idx = head + PW'(i);
                end
                if (i == 0 && busy_load)
                    keep = keep + CW'(1);
                else if (run && (cmt[head + PW'(i)] || commit_hit[head + PW'(i)]))
                    keep = keep + CW'(1);
                else
                    run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && enq)
            q[tail] <= '{op: ls_op_type, tag: ls_ins_rnm, addr: ls_ins_rs1 + ls_addr_offset,
                         data: store_ins_rs2};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            cmt               <= '0;
            ann               <= '0;
            state             <= S_IDLE;
            mem.mem_req       <= 1'b0;
            mem.mem_we        <= 1'b0;
            mem.mem_len       <= '0;
            mem.mem_addr      <= '0;
            mem.mem_wdata     <= '0;
            lsb_result_flag   <= 1'b0;
            lsb_result_rename <= '0;
            lsb_result_value  <= '0;
        end else if (rdy) begin
            lsb_result_flag <= 1'b0;
            cmt <= cmt | commit_hit;
            if (load_bcast) begin
                lsb_result_flag   <= 1'b1;
                lsb_result_rename <= hd.tag;
                lsb_result_value  <= ld_value;
            end else if (note_vld && !lsb_flush) begin
                lsb_result_flag   <= 1'b1;
                lsb_result_rename <= q[note_idx].tag;
                lsb_result_value  <= '0;
                ann[note_idx]     <= 1'b1;
            end
            if (enq) begin
                cmt[tail] <= 1'b0;
                ann[tail] <= 1'b0;
            end

            if (done) head <= head + PW'(1);
            if (lsb_flush) begin
                tail  <= head + keep[PW-1:0];
                count <= keep - CW'(done);
            end else begin
                if (enq) tail <= tail + PW'(1);
                count <= count + CW'(enq) - CW'(done);
            end

            case (state)
                S_IDLE: if (issue) begin
                    state         <= S_BUSY;
                    mem.mem_req   <= 1'b1;
                    mem.mem_we    <= is_store(hd.op);
                    mem.mem_len   <= op_len(hd.op);
                    mem.mem_addr  <= hd.addr;
                    mem.mem_wdata <= hd.data;
                end
                S_BUSY: if (mem.mem_done) begin
                    state       <= S_IDLE;
                    mem.mem_req <= 1'b0;
                end else if (lsb_flush && !is_store(hd.op)) begin
                    state <= S_DRAIN;
                end
                S_DRAIN: if (mem.mem_done) begin
                    state       <= S_IDLE;
                    mem.mem_req <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        (rdy && ls_mission && !lsb_flush) |-> (count != CW'(LSBSIZE)));
endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: queue-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_load_store_buffer;
    import load_store_buffer_pkg::*;

    localparam int          LSBSIZE = 8;
    localparam logic [31:0] IO_BASE = 32'h30000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        ls_mission = 1'b0;
    logic [3:0]  ls_ins_rnm = '0;
    logic [5:0]  ls_op_type = '0;
    logic [31:0] ls_addr_offset = '0, ls_ins_rs1 = '0, store_ins_rs2 = '0;
    logic        lsb_full;
    logic        rob_store_commit = 1'b0;
    logic [3:0]  rob_commit_rename = '0, rob_head_rename = '0;
    logic        lsb_flush = 1'b0;
    logic        lsb_result_flag;
    logic [3:0]  lsb_result_rename;
    logic [31:0] lsb_result_value;

    load_store_buffer_if mem_bus();

    always #5 clk = ~clk;

    load_store_buffer #(.LSBSIZE(LSBSIZE), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ls_mission(ls_mission), .ls_ins_rnm(ls_ins_rnm), .ls_op_type(ls_op_type),
        .ls_addr_offset(ls_addr_offset), .ls_ins_rs1(ls_ins_rs1), .store_ins_rs2(store_ins_rs2),
        .lsb_full(lsb_full),
        .rob_store_commit(rob_store_commit), .rob_commit_rename(rob_commit_rename),
        .rob_head_rename(rob_head_rename), .lsb_flush(lsb_flush),
        .mem(mem_bus),
        .lsb_result_flag(lsb_result_flag), .lsb_result_rename(lsb_result_rename),
        .lsb_result_value(lsb_result_value)
    );

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
        bit          committed;
        bit          announced;
    } ment_t;

    ment_t       mq[$];
    bit          m_busy, m_drop;
    logic        e_req, e_we, e_flag;
    logic [1:0]  e_len;
    logic [31:0] e_addr, e_wdata, e_val;
    logic [3:0]  e_tag;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic bit st(input logic [5:0] op);
        return op >= 6'd16;
    endfunction

    function automatic logic [1:0] len_of(input logic [5:0] op);
        if (op == 6'd11 || op == 6'd14 || op == 6'd16) return 2'd0;
        if (op == 6'd12 || op == 6'd15 || op == 6'd17) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] ext(input logic [5:0] op, input logic [31:0] r);
        case (op)
            6'd11:   return 32'($signed(r[7:0]));
            6'd12:   return 32'($signed(r[15:0]));
            6'd14:   return 32'(r[7:0]);
            6'd15:   return 32'(r[15:0]);
            default: return r;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit issue, done, bcast, head_ld, take;
        int nidx, k, old_size;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_drop = 0;
            e_req = 0; e_we = 0; e_len = 0; e_addr = 0; e_wdata = 0;
            e_flag = 0; e_tag = 0; e_val = 0;
            return;
        end
        if (!rdy) return;
        old_size = mq.size();
        head_ld  = old_size > 0 && !st(mq[0].op);
        issue    = !m_busy && !lsb_flush && old_size > 0 &&
                   (st(mq[0].op) ? mq[0].committed
                                 : (mq[0].addr < IO_BASE || mq[0].tag == rob_head_rename));
        done     = m_busy && mem_bus.mem_done;
        bcast    = done && !m_drop && head_ld && !lsb_flush;
        take     = ls_mission && !lsb_flush && old_size < LSBSIZE;
        nidx = -1;
        foreach (mq[i]) if (nidx < 0 && st(mq[i].op) && !mq[i].announced) nidx = i;
        if (rob_store_commit)
            foreach (mq[i]) if (st(mq[i].op) && mq[i].tag == rob_commit_rename) mq[i].committed = 1;
        e_flag = 0;
        if (bcast) begin
            e_flag = 1; e_tag = mq[0].tag; e_val = ext(mq[0].op, mem_bus.mem_rdata);
        end else if (nidx >= 0 && !lsb_flush) begin
            e_flag = 1; e_tag = mq[nidx].tag; e_val = 0; mq[nidx].announced = 1;
        end
        if (lsb_flush) begin
            k = (m_busy && head_ld) ? 1 : 0;
            while (k < mq.size() && mq[k].committed) k++;
            while (mq.size() > k) void'(mq.pop_back());
            if (m_busy && head_ld && !done) m_drop = 1;
        end
        if (done) begin
            void'(mq.pop_front());
            m_busy = 0; m_drop = 0; e_req = 0;
        end
        if (take)
            mq.push_back('{op: ls_op_type, tag: ls_ins_rnm, addr: ls_ins_rs1 + ls_addr_offset,
                           data: store_ins_rs2, committed: 0, announced: 0});
        if (issue) begin
            m_busy = 1; e_req = 1;
            e_we = st(mq[0].op); e_len = len_of(mq[0].op);
            e_addr = mq[0].addr; e_wdata = mq[0].data;
        end
    endtask

    task automatic compare_all();
        chk("mem_req", 32'(mem_bus.mem_req), 32'(e_req));
        chk("lsb_full", 32'(lsb_full), 32'(mq.size() >= LSBSIZE - 1));
        chk("result_flag", 32'(lsb_result_flag), 32'(e_flag));
        if (e_req) begin
            chk("mem_we", 32'(mem_bus.mem_we), 32'(e_we));
            chk("mem_len", 32'(mem_bus.mem_len), 32'(e_len));
            chk("mem_addr", mem_bus.mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_bus.mem_wdata, e_wdata);
        end
        if (e_flag) begin
            chk("result_rename", 32'(lsb_result_rename), 32'(e_tag));
            chk("result_value", lsb_result_value, e_val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        ls_mission = 0; rob_store_commit = 0; lsb_flush = 0; mem_bus.mem_done = 0;
    endtask

    task automatic mission(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] rs1,
                           input logic [31:0] off, input logic [31:0] data);
        ls_mission = 1; ls_op_type = op; ls_ins_rnm = tag;
        ls_ins_rs1 = rs1; ls_addr_offset = off; store_ins_rs2 = data;
    endtask

    task automatic dir_load(input string nm, input logic [5:0] op, input logic [3:0] tag,
                            input logic [31:0] rs1, input logic [31:0] off, input logic [31:0] rdata,
                            input logic [31:0] x_addr, input logic [1:0] x_len, input logic [31:0] x_val);
        mission(op, tag, rs1, off, 32'h0);
        step();
        step();
        chk({nm, "_req"}, 32'(mem_bus.mem_req), 32'd1);
        chk({nm, "_addr"}, mem_bus.mem_addr, x_addr);
        chk({nm, "_len"}, 32'(mem_bus.mem_len), 32'(x_len));
        mem_bus.mem_done = 1; mem_bus.mem_rdata = rdata;
        step();
        chk({nm, "_flag"}, 32'(lsb_result_flag), 32'd1);
        chk({nm, "_tag"}, 32'(lsb_result_rename), 32'(tag));
        chk({nm, "_val"}, lsb_result_value, x_val);
    endtask

    initial begin
        logic [3:0] tag_ctr;
        mem_bus.mem_done = 0; mem_bus.mem_rdata = '0;
        rst = 1;
        step(); step();
        rst = 0;
        step();
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_flag", 32'(lsb_result_flag), 32'd0);
        chk("rst_full", 32'(lsb_full), 32'd0);
        chk("rst_value", lsb_result_value, 32'd0);

        dir_load("lw",  6'd13, 4'd3, 32'h100, 32'd4, 32'hDEADBEEF, 32'h104, 2'd2, 32'hDEADBEEF);
        dir_load("lb",  6'd11, 4'd4, 32'h100, 32'd0, 32'h80, 32'h100, 2'd0, 32'hFFFFFF80);
        dir_load("lbu", 6'd14, 4'd6, 32'h100, 32'd0, 32'h80, 32'h100, 2'd0, 32'h00000080);
        dir_load("lh",  6'd12, 4'd1, 32'h100, 32'd2, 32'h8001, 32'h102, 2'd1, 32'hFFFF8001);
        dir_load("wrap", 6'd13, 4'd2, 32'hFFFFFFF0, 32'h20, 32'h1, 32'h10, 2'd2, 32'h1);

        // store waits for commit, notice goes out first
        mission(6'd18, 4'd5, 32'h200, 32'd8, 32'h1234);
        step();
        step();
        chk("sw_note_flag", 32'(lsb_result_flag), 32'd1);
        chk("sw_note_tag", 32'(lsb_result_rename), 32'd5);
        chk("sw_note_val", lsb_result_value, 32'd0);
        step(); step();
        chk("sw_wait_req", 32'(mem_bus.mem_req), 32'd0);
        rob_store_commit = 1; rob_commit_rename = 4'd5;
        step();
        step();
        chk("sw_req", 32'(mem_bus.mem_req), 32'd1);
        chk("sw_we", 32'(mem_bus.mem_we), 32'd1);
        chk("sw_addr", mem_bus.mem_addr, 32'h208);
        chk("sw_wdata", mem_bus.mem_wdata, 32'h1234);
        mem_bus.mem_done = 1;
        step();
        chk("sw_done_req", 32'(mem_bus.mem_req), 32'd0);

        // committed store survives flush, loads behind it are dropped
        mission(6'd18, 4'd1, 32'h300, 32'd0, 32'hAA);
        step();
        mission(6'd13, 4'd2, 32'h40, 32'd0, 32'h0);
        step();
        mission(6'd13, 4'd3, 32'h44, 32'd0, 32'h0);
        step();
        rob_store_commit = 1; rob_commit_rename = 4'd1; lsb_flush = 1;
        step();
        step();
        chk("fl_sw_req", 32'(mem_bus.mem_req), 32'd1);
        chk("fl_sw_we", 32'(mem_bus.mem_we), 32'd1);
        chk("fl_sw_addr", mem_bus.mem_addr, 32'h300);
        mem_bus.mem_done = 1;
        step();
        chk("fl_model_empty", 32'(mq.size()), 32'd0);
        rob_head_rename = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_load_req", 32'(mem_bus.mem_req), 32'd0);
        end

        // IO load waits until it is the ROB head
        mission(6'd13, 4'd7, 32'h30000, 32'd0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("io_wait_req", 32'(mem_bus.mem_req), 32'd0);
        end
        rob_head_rename = 4'd7;
        step();
        chk("io_req", 32'(mem_bus.mem_req), 32'd1);
        chk("io_addr", mem_bus.mem_addr, 32'h30000);
        mem_bus.mem_done = 1; mem_bus.mem_rdata = 32'h55;
        step();
        chk("io_tag", 32'(lsb_result_rename), 32'd7);
        chk("io_val", lsb_result_value, 32'h55);
        rob_head_rename = 4'd0;

        // fill to the full margin, rdy stall while busy, one dequeue clears full
        for (int i = 0; i < LSBSIZE - 1; i++) begin
            if (i == LSBSIZE - 2) chk("full_pre", 32'(lsb_full), 32'd0);
            mission(6'd18, 4'(8 + i), 32'h1000 + 32'(4 * i), 32'd0, 32'(i));
            step();
        end
        chk("full_set", 32'(lsb_full), 32'd1);
        rob_store_commit = 1; rob_commit_rename = 4'd8;
        step();
        step();
        chk("stall_req0", 32'(mem_bus.mem_req), 32'd1);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", 32'(mem_bus.mem_req), 32'd1);
            chk("stall_addr", mem_bus.mem_addr, 32'h1000);
        end
        rdy = 1;
        mem_bus.mem_done = 1;
        step();
        chk("full_clear", 32'(lsb_full), 32'd0);
        lsb_flush = 1;
        step();
        step();

        // randomized traffic
        tag_ctr = 4'd0;
        for (int c = 0; c < 4000; c++) begin
            int ci;
            rdy = ($urandom_range(0, 9) != 0);
            if (mq.size() < LSBSIZE - 1 && $urandom_range(0, 1) == 1) begin
                logic [31:0] rs1;
                case ($urandom_range(0, 3))
                    0:       rs1 = IO_BASE + 32'($urandom_range(0, 64));
                    1:       rs1 = 32'hFFFFFFF8;
                    default: rs1 = 32'($urandom_range(0, 4095));
                endcase
                mission(6'($urandom_range(11, 18)), tag_ctr, rs1,
                        32'($signed($urandom_range(0, 63)) - 32),
                        $urandom);
                tag_ctr = tag_ctr + 4'd1;
            end
            ci = -1;
            foreach (mq[i]) if (ci < 0 && st(mq[i].op) && mq[i].announced && !mq[i].committed) ci = i;
            if (ci >= 0 && $urandom_range(0, 2) == 0) begin
                rob_store_commit = 1; rob_commit_rename = mq[ci].tag;
            end else if ($urandom_range(0, 19) == 0) begin
                rob_store_commit = 1; rob_commit_rename = 4'($urandom);
            end
            rob_head_rename = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].tag : 4'($urandom);
            lsb_flush = ($urandom_range(0, 49) == 0);
            mem_bus.mem_rdata = $urandom;
            mem_bus.mem_done = m_busy && ($urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
